// File: rtl/bitcell_mem_array.sv
// Word-organised storage array built on the bitcell access semantics:
// sel enables an access, r_w=1 writes (bit-masked), r_w=0 reads into a
// registered output with a one-cycle valid strobe. After every reset a
// clear sequence zeroes each word before any access is accepted.
module bitcell_mem_array #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  in,
  input  logic [WIDTH-1:0]  wmask,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_last;
  logic              in_range_p0;
  logic              wr_en_p0;
  logic              rd_en_p0;
  logic [WIDTH-1:0]  rd_data_p0;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Only the bits selected by the mask take the new value.
  function automatic logic [WIDTH-1:0] merge_bits(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [WIDTH-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // ---- p0: request decode (addresses >= DEPTH exist only for non-power-of-two depths)
  assign in_range_p0 = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign clr_last    = (clr_ptr == ADDR_W'(DEPTH - 1));
  assign wr_en_p0    = (state == IDLE) && sel && r_w && in_range_p0;
  assign rd_en_p0    = (state == IDLE) && sel && !r_w;
  assign rd_data_p0  = in_range_p0 ? mem[addr] : '0;

  // FSM state register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
      end
    end
  end

  // Next-state logic; busy covers the whole clear sequence
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Storage: clear sweep or masked write; nothing is written at a reset edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en_p0) begin
        mem[addr] <= merge_bits(mem[addr], in, wmask);
      end
    end
  end

  // ---- p1: registered read data and its valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en_p0;
      if (rd_en_p0) begin
        out <= rd_data_p0;
      end
    end
  end

endmodule
